// File: rtl/uart_packet_deframer.sv
`default_nettype none
// ============================================================================
// Module   : uart_packet_deframer
// Purpose  : Extracts SOF/LEN/PAYLOAD/XOR-CSUM frames from a UART RX byte
//            stream. Holds a verified payload until the consumer acks it.
// Revision : 1.0  initial release
// ============================================================================
module uart_packet_deframer #(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000,
    localparam int        AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          hb_clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          pkt_valid,
    output logic [7:0]    pkt_len,
    input  logic          pkt_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          err_len,
    output logic          err_csum,
    output logic          err_timeout,
    output logic [7:0]    err_cnt
);

    localparam logic [7:0] c_max_len = 8'(MAX_LEN);
    localparam int         c_cnt_w   = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHECK   = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [7:0]           r_len;
    logic [7:0]           r_csum;
    logic [7:0]           r_idx;
    logic [c_cnt_w-1:0]   r_tmo_cnt;
    logic [7:0]           r_buf [0:MAX_LEN-1];

    logic w_acc;
    logic w_in_frame;
    logic w_tmo_hit;
    logic w_len_bad;
    logic w_set_err_len;
    logic w_set_err_csum;
    logic w_set_err_tmo;
    logic w_pkt_load;
    logic w_pkt_release;
    logic w_buf_wr;

    // Backpressure depends only on the state register, never on in_valid.
    assign in_ready   = (r_state != S_HOLD);
    assign w_acc      = in_valid && in_ready;
    assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHECK);
    // Counter about to reach TIMEOUT_CYCLES-1 on this edge.
    assign w_tmo_hit  = (r_tmo_cnt == c_cnt_w'(TIMEOUT_CYCLES - 2));
    assign w_len_bad  = (in_data == 8'd0) || (in_data > c_max_len);
    assign w_buf_wr   = (r_state == S_PAYLOAD) && w_acc;

    // Next-state and event decode; an accepted byte always beats the timeout.
    always_comb begin
        w_state_next   = r_state;
        w_set_err_len  = 1'b0;
        w_set_err_csum = 1'b0;
        w_set_err_tmo  = 1'b0;
        w_pkt_load     = 1'b0;
        w_pkt_release  = 1'b0;
        case (r_state)
            S_HUNT: begin
                if (w_acc && (in_data == SOF_BYTE)) w_state_next = S_LEN;
            end
            S_LEN: begin
                if (w_acc) begin
                    if (w_len_bad) begin
                        w_set_err_len = 1'b1;
                        w_state_next  = S_HUNT;
                    end else begin
                        w_state_next  = S_PAYLOAD;
                    end
                end else if (w_tmo_hit) begin
                    w_set_err_tmo = 1'b1;
                    w_state_next  = S_HUNT;
                end
            end
            S_PAYLOAD: begin
                if (w_acc) begin
                    if (r_idx == (r_len - 8'd1)) w_state_next = S_CHECK;
                end else if (w_tmo_hit) begin
                    w_set_err_tmo = 1'b1;
                    w_state_next  = S_HUNT;
                end
            end
            S_CHECK: begin
                if (w_acc) begin
                    if (in_data == r_csum) begin
                        w_pkt_load   = 1'b1;
                        w_state_next = S_HOLD;
                    end else begin
                        w_set_err_csum = 1'b1;
                        w_state_next   = S_HUNT;
                    end
                end else if (w_tmo_hit) begin
                    w_set_err_tmo = 1'b1;
                    w_state_next  = S_HUNT;
                end
            end
            S_HOLD: begin
                if (pkt_ack) begin
                    w_pkt_release = 1'b1;
                    w_state_next  = S_HUNT;
                end
            end
            default: w_state_next = S_HUNT;
        endcase
    end

    // State register.
    always_ff @(posedge hb_clk) begin
        if (rst) r_state <= S_HUNT;
        else     r_state <= w_state_next;
    end

    // Frame datapath, held-packet registers, error pulses and timeout counter.
    always_ff @(posedge hb_clk) begin
        if (rst) begin
            r_len       <= 8'd0;
            r_csum      <= 8'd0;
            r_idx       <= 8'd0;
            r_tmo_cnt   <= '0;
            pkt_valid   <= 1'b0;
            pkt_len     <= 8'd0;
            err_len     <= 1'b0;
            err_csum    <= 1'b0;
            err_timeout <= 1'b0;
            err_cnt     <= 8'd0;
        end else begin
            err_len     <= w_set_err_len;
            err_csum    <= w_set_err_csum;
            err_timeout <= w_set_err_tmo;
            if ((w_set_err_len || w_set_err_csum || w_set_err_tmo) && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;

            if ((r_state == S_LEN) && w_acc && !w_len_bad) begin
                r_len  <= in_data;
                r_csum <= in_data;
                r_idx  <= 8'd0;
            end else if (w_buf_wr) begin
                r_csum <= r_csum ^ in_data;
                r_idx  <= r_idx + 8'd1;
            end

            if (w_pkt_load) begin
                pkt_len   <= r_len;
                pkt_valid <= 1'b1;
            end else if (w_pkt_release) begin
                pkt_valid <= 1'b0;
            end

            if (w_in_frame && !w_acc && !w_tmo_hit) r_tmo_cnt <= r_tmo_cnt + 1'b1;
            else                                     r_tmo_cnt <= '0;
        end
    end

    // Payload storage; never written outside PAYLOAD so a held packet is stable.
    always_ff @(posedge hb_clk) begin
        if (w_buf_wr) r_buf[r_idx[AW-1:0]] <= in_data;
    end

    // Registered payload read port.
    always_ff @(posedge hb_clk) begin
        if (rst) rd_data <= 8'd0;
        else     rd_data <= r_buf[rd_addr];
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_packet_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_packet_deframer
// Purpose  : Directed and randomized frame stimulus for uart_packet_deframer,
//            checked against expectations built from the frame format.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_packet_deframer;

    logic       hb_clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       pkt_valid;
    logic [7:0] pkt_len;
    logic       pkt_ack;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       err_len;
    logic       err_csum;
    logic       err_timeout;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;
    int exp_errs = 0;
    int n_len = 0, n_csum = 0, n_tmo = 0, n_multi = 0;
    int cyc = 0, tmo_cyc = -1;

    uart_packet_deframer #(
        .MAX_LEN        (16),
        .SOF_BYTE       (8'hA5),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .hb_clk      (hb_clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .pkt_valid   (pkt_valid),
        .pkt_len     (pkt_len),
        .pkt_ack     (pkt_ack),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .err_len     (err_len),
        .err_csum    (err_csum),
        .err_timeout (err_timeout),
        .err_cnt     (err_cnt)
    );

    always #5 hb_clk = ~hb_clk;

    // Cycle counter, advanced on every active edge.
    always @(posedge hb_clk) cyc <= cyc + 1;

    // Error-pulse monitor sampled on the inactive edge.
    always @(negedge hb_clk) begin
        if (err_len)  n_len++;
        if (err_csum) n_csum++;
        if (err_timeout) begin
            n_tmo++;
            tmo_cyc = cyc;
        end
        if ((int'(err_len) + int'(err_csum) + int'(err_timeout)) > 1) n_multi++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bump_err();
        exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge hb_clk); #1;
        end
    endtask

    // Present one byte and return just after the edge that accepts it.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 100) begin
            @(posedge hb_clk); #1;
            guard++;
        end
        if (guard >= 100) chk("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge hb_clk); #1;
    endtask

    task automatic send_frame(input logic [7:0] f[$], input int gap_max);
        foreach (f[i]) begin
            send_byte(f[i]);
            if (gap_max > 0 && i < f.size() - 1) idle($urandom_range(0, gap_max));
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] len, input logic [7:0] p[$]);
        logic [7:0] x;
        x = len;
        foreach (p[i]) x = x ^ p[i];
        return x;
    endfunction

    // Build SOF, LEN, payload, checksum (optionally corrupted).
    function automatic void make_frame(input logic [7:0] p[$], input logic [7:0] corrupt,
                                       output logic [7:0] f[$]);
        f = {};
        f.push_back(8'hA5);
        f.push_back(8'(p.size()));
        foreach (p[i]) f.push_back(p[i]);
        f.push_back(xsum(8'(p.size()), p) ^ corrupt);
    endfunction

    task automatic expect_pkt(input string tag, input logic [7:0] p[$]);
        chk({tag, "_valid"}, 32'(pkt_valid), 32'd1);
        chk({tag, "_len"}, 32'(pkt_len), 32'(p.size()));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        foreach (p[i]) begin
            rd_addr = 4'(i);
            @(posedge hb_clk); #1;
            chk({tag, "_data"}, 32'(rd_data), 32'(p[i]));
        end
    endtask

    task automatic ack_pkt(input string tag);
        pkt_ack = 1'b1;
        @(posedge hb_clk); #1;
        pkt_ack = 1'b0;
        chk({tag, "_ack_valid"}, 32'(pkt_valid), 32'd0);
        chk({tag, "_ack_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] p[$];
        logic [7:0] f[$];
        int acc_cyc, t0, exp_csum_n;
        logic [7:0] cor;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; pkt_ack = 1'b0; rd_addr = 4'd0;
        repeat (3) begin
            @(posedge hb_clk); #1;
        end
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        chk("rst_pkt_len", 32'(pkt_len), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_err_pulses", {29'd0, err_len, err_csum, err_timeout}, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;

        // Good packet, bytes back to back.
        f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_frame(f, 0);
        p = '{8'h11, 8'h22, 8'h33};
        expect_pkt("good", p);
        ack_pkt("good");

        // Bad checksum, then a one-byte packet.
        f = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        send_frame(f, 0);
        idle(1);
        bump_err();
        chk("csum_pulses", n_csum, 1);
        chk("csum_err_cnt", 32'(err_cnt), exp_errs);
        chk("csum_no_pkt", 32'(pkt_valid), 32'd0);
        f = '{8'hA5, 8'h01, 8'h7F, 8'h7E};
        send_frame(f, 0);
        p = '{8'h7F};
        expect_pkt("one", p);
        ack_pkt("one");

        // Length 0 and MAX_LEN+1 are rejected; MAX_LEN is accepted.
        f = '{8'hA5, 8'h00};
        send_frame(f, 0);
        f = '{8'hA5, 8'h11};
        send_frame(f, 0);
        idle(1);
        bump_err(); bump_err();
        chk("len_pulses", n_len, 2);
        chk("len_err_cnt", 32'(err_cnt), exp_errs);
        p = {};
        for (int i = 0; i < 16; i++) p.push_back(8'($urandom));
        make_frame(p, 8'h00, f);
        send_frame(f, 0);
        expect_pkt("max", p);
        ack_pkt("max");

        // Leading noise is discarded in HUNT.
        p = '{8'hC3, 8'h3C};
        make_frame(p, 8'h00, f);
        f.push_front(8'h5A); f.push_front(8'hFF); f.push_front(8'h00);
        send_frame(f, 0);
        expect_pkt("noise", p);
        ack_pkt("noise");

        // Inter-byte timeout fires 49 cycles after the last accept.
        t0 = n_tmo;
        f = '{8'hA5, 8'h02, 8'hAA};
        send_frame(f, 0);
        acc_cyc = cyc;
        idle(60);
        bump_err();
        chk("tmo_pulses", n_tmo - t0, 1);
        chk("tmo_latency", tmo_cyc - acc_cyc, 49);
        chk("tmo_err_cnt", 32'(err_cnt), exp_errs);
        chk("tmo_in_ready", 32'(in_ready), 32'd1);

        // A byte accepted on the expiry cycle wins over the timeout.
        t0 = n_tmo;
        f = '{8'hA5, 8'h02, 8'hAA};
        send_frame(f, 0);
        idle(48);
        send_byte(8'hBB);
        send_byte(8'h02 ^ 8'hAA ^ 8'hBB);
        in_valid = 1'b0;
        p = '{8'hAA, 8'hBB};
        expect_pkt("tmo_edge", p);
        chk("tmo_edge_none", n_tmo - t0, 0);
        ack_pkt("tmo_edge");

        // Backpressure in HOLD: nothing consumed, buffer stable.
        p = {};
        for (int i = 0; i < 5; i++) p.push_back(8'($urandom));
        make_frame(p, 8'h00, f);
        send_frame(f, 0);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (8) begin
            @(posedge hb_clk); #1;
        end
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_valid_held", 32'(pkt_valid), 32'd1);
        expect_pkt("bp", p);
        ack_pkt("bp");
        send_byte(8'hA5);
        p = '{8'h5C, 8'hE1};
        f = '{8'h02, 8'h5C, 8'hE1, 8'h02 ^ 8'h5C ^ 8'hE1};
        send_frame(f, 0);
        expect_pkt("bp_next", p);
        ack_pkt("bp_next");

        // Randomized packets with noise, gaps and occasional corruption.
        exp_csum_n = n_csum;
        for (int k = 0; k < 40; k++) begin
            int nn;
            logic [7:0] nb;
            nn = $urandom_range(0, 3);
            f = {};
            for (int j = 0; j < nn; j++) begin
                nb = 8'($urandom);
                if (nb == 8'hA5) nb = 8'h00;
                f.push_back(nb);
            end
            pkt_ack = 1'b1;
            send_frame(f, 2);
            pkt_ack = 1'b0;
            p = {};
            nn = $urandom_range(1, 16);
            for (int j = 0; j < nn; j++) p.push_back(8'($urandom));
            cor = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            make_frame(p, cor, f);
            send_frame(f, 5);
            if (cor != 8'h00) begin
                idle(1);
                bump_err();
                exp_csum_n++;
                chk("rnd_csum_pulses", n_csum, exp_csum_n);
                chk("rnd_csum_no_pkt", 32'(pkt_valid), 32'd0);
                chk("rnd_err_cnt", 32'(err_cnt), exp_errs);
            end else begin
                expect_pkt("rnd", p);
                ack_pkt("rnd");
            end
        end

        // Error counter saturation.
        t0 = n_len;
        for (int k = 0; k < 300; k++) begin
            f = '{8'hA5, 8'h11};
            send_frame(f, 0);
            bump_err();
        end
        idle(1);
        chk("sat_len_pulses", n_len - t0, 300);
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);

        // Reset in the middle of a payload discards the frame.
        f = '{8'hA5, 8'h05, 8'h01, 8'h02};
        send_frame(f, 0);
        rst = 1'b1;
        @(posedge hb_clk); #1;
        chk("mrst_err_cnt", 32'(err_cnt), 32'd0);
        chk("mrst_pkt_valid", 32'(pkt_valid), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_pkt_len", 32'(pkt_len), 32'd0);
        rst = 1'b0;
        exp_errs = 0;
        f = '{8'hA5, 8'h01, 8'h42, 8'h43};
        send_frame(f, 0);
        p = '{8'h42};
        expect_pkt("post_rst", p);
        chk("post_rst_err_cnt", 32'(err_cnt), exp_errs);
        ack_pkt("post_rst");

        idle(2);
        chk("err_exclusive", n_multi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
